// File: rtl/gf180mcu_ocd_io__dvdd_seq.sv
// rtl/gf180mcu_ocd_io__dvdd_seq.sv - DVDD pad-group supply sequencer with power-good qualification and fault latch
module gf180mcu_ocd_io__dvdd_seq #(
    parameter int NCH      = 4,
    parameter int DEB_CNT  = 16,
    parameter int STEP_DLY = 32,
    parameter int TIMEOUT  = 255,
    parameter int FCW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           REQ,
    input  logic           CLR,
    input  logic [NCH-1:0] PG,
    output logic [NCH-1:0] EN,
    output logic           READY,
    output logic           BUSY,
    output logic           FAULT,
    output logic [FCW-1:0] FAULT_CH
);

    typedef enum logic [2:0] {
        S_OFF,
        S_UP,
        S_SETTLE,
        S_ON,
        S_DOWN,
        S_FAULT
    } state_t;

    localparam logic [7:0]     DEB_V      = 8'(DEB_CNT);
    localparam logic [9:0]     TMO_V      = 10'(TIMEOUT);
    localparam logic [9:0]     SETTLE_END = 10'(STEP_DLY - 1);
    localparam logic [9:0]     STEP_END   = 10'(STEP_DLY);
    localparam logic [FCW-1:0] LAST       = FCW'(NCH - 1);

    state_t         state_q, state_d;
    logic [FCW-1:0] idx_q, idx_d, idx_inc, idx_dec;
    logic [9:0]     tmr_q, tmr_d;
    logic [NCH-1:0] en_d;
    logic [FCW-1:0] fault_ch_d;

    logic [NCH-1:0] pg_m, pg_s, pg_ok;
    logic [7:0]     deb_cnt [NCH];

    logic [NCH-1:0] drop_up, drop_settle;
    logic           do_fault, do_down;
    logic [FCW-1:0] fault_idx, down_idx;

    function automatic logic [FCW-1:0] lowest(input logic [NCH-1:0] m);
        lowest = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) lowest = FCW'(i);
        end
    endfunction

    // Rising PG must survive DEB_CNT synchronised cycles; a falling PG is seen immediately.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pg_m <= '0;
            pg_s <= '0;
            for (int i = 0; i < NCH; i++) deb_cnt[i] <= '0;
        end else begin
            pg_m <= PG;
            pg_s <= pg_m;
            for (int i = 0; i < NCH; i++) begin
                if (!pg_s[i])              deb_cnt[i] <= '0;
                else if (deb_cnt[i] != DEB_V) deb_cnt[i] <= deb_cnt[i] + 8'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) pg_ok[i] = pg_s[i] && (deb_cnt[i] == DEB_V);
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tmr_d      = tmr_q;
        en_d       = EN;
        fault_ch_d = FAULT_CH;
        do_fault   = 1'b0;
        do_down    = 1'b0;
        fault_idx  = '0;
        down_idx   = idx_q;
        idx_inc    = idx_q + FCW'(1);
        idx_dec    = idx_q - FCW'(1);
        drop_up    = '0;
        drop_settle = '0;
        for (int i = 0; i < NCH; i++) begin
            drop_up[i]     = !pg_ok[i] && (i < int'(idx_q));
            drop_settle[i] = !pg_ok[i] && (i <= int'(idx_q));
        end

        case (state_q)
            S_OFF: begin
                en_d = '0;
                if (REQ && !FAULT) begin
                    state_d = S_UP;
                    idx_d   = '0;
                    en_d[0] = 1'b1;
                    tmr_d   = '0;
                end
            end
            S_UP: begin
                tmr_d = tmr_q + 10'd1;
                if (|drop_up) begin
                    do_fault  = 1'b1;
                    fault_idx = lowest(drop_up);
                end else if (!pg_ok[idx_q] && tmr_q == TMO_V) begin
                    do_fault  = 1'b1;
                    fault_idx = idx_q;
                end else if (!REQ) begin
                    do_down = 1'b1;
                end else if (pg_ok[idx_q]) begin
                    if (idx_q == LAST) begin
                        state_d = S_ON;
                    end else begin
                        state_d = S_SETTLE;
                        tmr_d   = '0;
                    end
                end
            end
            S_SETTLE: begin
                if (|drop_settle) begin
                    do_fault  = 1'b1;
                    fault_idx = lowest(drop_settle);
                end else if (!REQ) begin
                    do_down = 1'b1;
                end else if (tmr_q == SETTLE_END) begin
                    state_d       = S_UP;
                    idx_d         = idx_inc;
                    en_d[idx_inc] = 1'b1;
                    tmr_d         = '0;
                end else begin
                    tmr_d = tmr_q + 10'd1;
                end
            end
            S_ON: begin
                if (!(&pg_ok)) begin
                    do_fault  = 1'b1;
                    fault_idx = lowest(~pg_ok);
                end else if (!REQ) begin
                    do_down  = 1'b1;
                    down_idx = LAST;
                end
            end
            S_DOWN: begin
                if (tmr_q == STEP_END) begin
                    if (idx_q == '0) begin
                        state_d = S_OFF;
                    end else begin
                        idx_d         = idx_dec;
                        en_d[idx_dec] = 1'b0;
                        tmr_d         = '0;
                    end
                end else begin
                    tmr_d = tmr_q + 10'd1;
                end
            end
            S_FAULT: begin
                en_d = '0;
                if (CLR && !REQ) begin
                    state_d    = S_OFF;
                    fault_ch_d = '0;
                end
            end
            default: state_d = S_OFF;
        endcase

        // Faults outrank a request drop, which outranks the normal advance above.
        if (do_fault) begin
            state_d    = S_FAULT;
            en_d       = '0;
            fault_ch_d = fault_idx;
            idx_d      = '0;
            tmr_d      = '0;
        end else if (do_down) begin
            state_d        = S_DOWN;
            idx_d          = down_idx;
            en_d[down_idx] = 1'b0;
            tmr_d          = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_OFF;
            idx_q    <= '0;
            tmr_q    <= '0;
            EN       <= '0;
            READY    <= 1'b0;
            BUSY     <= 1'b0;
            FAULT    <= 1'b0;
            FAULT_CH <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tmr_q    <= tmr_d;
            EN       <= en_d;
            READY    <= (state_d == S_ON);
            BUSY     <= (state_d == S_UP) || (state_d == S_SETTLE) || (state_d == S_DOWN);
            FAULT    <= (state_d == S_FAULT);
            FAULT_CH <= fault_ch_d;
        end
    end

endmodule

// File: tb/tb_gf180mcu_ocd_io__dvdd_seq.sv
// tb/tb_gf180mcu_ocd_io__dvdd_seq.sv - timeline-model bench for the DVDD sequencer
module tb_gf180mcu_ocd_io__dvdd_seq;

    localparam int NCH  = 4;
    localparam int DEB  = 4;
    localparam int STEP = 8;
    localparam int TMO  = 20;
    localparam int NEVER = 1 << 20;

    logic       CLK = 1'b0;
    logic       RST, REQ, CLR;
    logic [3:0] PG, EN;
    logic       READY, BUSY, FAULT;
    logic [1:0] FAULT_CH;
    logic [8:0] obs;

    gf180mcu_ocd_io__dvdd_seq #(
        .NCH(NCH), .DEB_CNT(DEB), .STEP_DLY(STEP), .TIMEOUT(TMO)
    ) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .CLR(CLR), .PG(PG),
        .EN(EN), .READY(READY), .BUSY(BUSY), .FAULT(FAULT), .FAULT_CH(FAULT_CH)
    );

    always #5 CLK = ~CLK;
    assign obs = {EN, READY, BUSY, FAULT, FAULT_CH};

    int nvec = 0;
    int nerr = 0;
    int c;
    int dly [4];
    int ten [4];
    int ton, tfault, fch;

    function automatic logic [8:0] pack(logic [3:0] en, logic rdy, logic bsy, logic flt, logic [1:0] ch);
        return {en, rdy, bsy, flt, ch};
    endfunction

    task automatic tick;
        @(posedge CLK);
        #1;
        c++;
    endtask

    task automatic chk(input string tag, input logic [8:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b (EN,RDY,BSY,FLT,CH)", tag, c, obs, expv);
        end
    endtask

    task automatic do_reset;
        RST = 1'b1; REQ = 1'b0; CLR = 1'b0; PG = 4'b0;
        tick;
        tick;
        chk("reset", 9'b0);
        RST = 1'b0;
        c = 0;
    endtask

    // Each group's enable time follows from the previous one: PG delay, 2 sync, DEB qualify,
    // 1 register, then STEP settle. A PG that qualifies after tmr passes TIMEOUT faults instead.
    task automatic plan;
        int t;
        t = 1; ton = NEVER; tfault = NEVER; fch = 0;
        for (int i = 0; i < NCH; i++) ten[i] = NEVER;
        for (int i = 0; i < NCH; i++) begin
            ten[i] = t;
            if (dly[i] + 2 + DEB <= TMO) begin
                if (i == NCH - 1) ton = t + dly[i] + 3 + DEB;
                else              t   = t + dly[i] + 3 + DEB + STEP;
            end else begin
                tfault = t + TMO + 1;
                fch    = i;
                break;
            end
        end
    endtask

    function automatic logic [8:0] exp_up(int cc);
        logic [3:0] en;
        logic       flt;
        en = '0;
        for (int i = 0; i < NCH; i++) if (ten[i] <= cc) en[i] = 1'b1;
        flt = (cc >= tfault);
        if (flt) en = '0;
        return pack(en, cc >= ton, (cc >= 1) && (cc < ton) && (cc < tfault), flt,
                    flt ? 2'(fch) : 2'b0);
    endfunction

    task automatic run_up(input string tag);
        int lim;
        lim = ((ton < tfault) ? ton : tfault) + 3;
        REQ = 1'b1;
        while (c < lim) begin
            tick;
            chk(tag, exp_up(c));
            for (int i = 0; i < NCH; i++) PG[i] = (ten[i] <= c) && (c >= ten[i] + dly[i]);
        end
    endtask

    task automatic run_down(input string tag);
        int td;
        logic [3:0] en;
        td = c + 1;
        REQ = 1'b0;
        while (c < td + 38) begin
            tick;
            for (int k = 0; k < NCH; k++) en[NCH-1-k] = (c < td + k * (STEP + 1));
            chk(tag, pack(en, 1'b0, c < td + 4 * (STEP + 1), 1'b0, 2'b0));
        end
    endtask

    task automatic run_clear(input string tag);
        CLR = 1'b1;
        repeat (3) begin
            tick;
            chk({tag, "_hold"}, pack(4'b0, 1'b0, 1'b0, 1'b1, 2'(fch)));
        end
        REQ = 1'b0;
        tick;
        chk({tag, "_clr"}, 9'b0);
        CLR = 1'b0;
        REQ = 1'b1;
        tick;
        chk({tag, "_rereq"}, pack(4'b0001, 1'b0, 1'b1, 1'b0, 2'b0));
    endtask

    initial begin
        // Nominal up and down, and a timeout on group 2.
        do_reset; dly = '{3, 3, 3, 3};   plan; run_up("up");    run_down("down");
        do_reset; dly = '{3, 3, 15, 3};  plan; run_up("tmo");   run_clear("tmo");
        // Timeout boundary: 14 just qualifies, 15 faults.
        do_reset; dly = '{14, 14, 14, 14}; plan; run_up("edge14"); run_down("edge14_dn");
        do_reset; dly = '{0, 0, 0, 15};  plan; run_up("edge15"); run_clear("edge15");

        for (int t = 0; t < 8; t++) begin
            do_reset;
            for (int i = 0; i < NCH; i++) dly[i] = int'($urandom_range(0, 17));
            plan;
            run_up("rnd_up");
            if (tfault != NEVER) run_clear("rnd_flt");
            else                 run_down("rnd_dn");
        end

        // Dropout of groups 1 and 3 together in ON.
        do_reset; dly = '{2, 2, 2, 2}; plan; run_up("pre_drop");
        PG[1] = 1'b0; PG[3] = 1'b0;
        tick; chk("drop1", pack(4'b1111, 1'b1, 1'b0, 1'b0, 2'b0));
        tick; chk("drop2", pack(4'b1111, 1'b1, 1'b0, 1'b0, 2'b0));
        tick; chk("drop3", pack(4'b0000, 1'b0, 1'b0, 1'b1, 2'd1));
        tick; chk("drop4", pack(4'b0000, 1'b0, 1'b0, 1'b1, 2'd1));

        // Glitchy PG[0]: high 3, low 1, then high; the last run alone qualifies.
        do_reset; REQ = 1'b1;
        while (c < 21) begin
            tick;
            chk("deb", pack((c >= 20) ? 4'b0011 : 4'b0001, 1'b0, 1'b1, 1'b0, 2'b0));
            PG[0] = ((c >= 1) && (c <= 3)) || (c >= 5);
        end

        // REQ drops in SETTLE at idx=1.
        do_reset; REQ = 1'b1;
        while (c < 46) begin
            logic [3:0] en;
            tick;
            if (c < 16)      en = 4'b0001;
            else if (c < 26) en = 4'b0011;
            else if (c < 35) en = 4'b0001;
            else             en = 4'b0000;
            chk("abort", pack(en, 1'b0, c < 44, 1'b0, 2'b0));
            PG[0] = (c >= 1);
            PG[1] = (c >= 16);
            if (c == 25) REQ = 1'b0;
        end

        // Reset mid-UP.
        do_reset; REQ = 1'b1;
        repeat (5) tick;
        chk("rst_pre", pack(4'b0001, 1'b0, 1'b1, 1'b0, 2'b0));
        RST = 1'b1; REQ = 1'b0;
        tick;
        chk("rst_up", 9'b0);
        RST = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/gf180mcu_ocd_io__dvdd_seq.md
# gf180mcu_ocd_io__dvdd_seq

Parametrised supply-domain sequencer for the DVDD pad ring. It drives the enables of NCH independent DVDD/DVSS pad groups, brings them up in ascending order and takes them down in descending order. It qualifies each group's analog power-good with synchronisation and debounce, and latches a fault when a group fails to come up or drops out. It sits in the always-on VDD/VSS core domain, between the chip power manager (REQ/CLR) and the DVDD pad cells.

## Interface
- NCH, 4: number of DVDD groups, 1..16.
- DEB_CNT, 16: consecutive synchronised-high cycles required to qualify PG, 1..255.
- STEP_DLY, 32: settle cycles between consecutive group steps, 1..1023.
- TIMEOUT, 255: cycles allowed for a group's PG to qualify after its enable, 1..1023.
- FCW, derived: max(1, clog2(NCH)).
- CLK  in  1  core clock; all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- REQ  in  1  level request; 1 = power up all groups, 0 = power down.
- CLR  in  1  fault clear; acts only when REQ=0.
- PG  in  NCH  asynchronous per-group power-good from the pad detectors.
- EN  out  NCH  per-group supply enable, registered.
- READY  out  1  all groups enabled and qualified.
- BUSY  out  1  sequencing in progress (UP/SETTLE/DOWN).
- FAULT  out  1  sticky fault flag.
- FAULT_CH  out  FCW  index of the faulting group; valid while FAULT=1.

## Operation
- PG path: per-bit 2-flop synchroniser to pg_s. Per-channel debounce counter clears when pg_s=0 and increments, saturating, while pg_s=1. pg_ok[i]=1 when count==DEB_CNT. Deassertion follows pg_s with no debounce.
- Registers: state, idx (current group), tmr (shared step timer, 10 bits).
- OFF: EN=0. REQ=1 and FAULT=0 -> UP, idx=0, EN[0]=1, tmr=0.
- UP: tmr increments each cycle.
  - pg_ok[idx]=1: go to ON if idx==NCH-1, otherwise go to SETTLE with tmr=0.
  - tmr==TIMEOUT with pg_ok[idx]=0: go to FAULT, FAULT_CH=idx.
- SETTLE: tmr counts to STEP_DLY-1, then idx+1, EN[idx+1]=1, tmr=0 -> UP.
- ON: READY=1.
  - Any pg_ok[i]=0: go to FAULT, FAULT_CH=lowest such i.
  - Otherwise REQ=0: go to DOWN, idx=NCH-1, tmr=0.
- DOWN: EN[idx]=0 on entry to each step. Wait STEP_DLY cycles.
  - idx>0: decrement idx and clear the next enable.
  - idx==0: go to OFF.
  - PG changes are ignored in DOWN.
- Abort during UP/SETTLE:
  - pg_ok drop on an already-qualified group (i<idx, or i==idx in SETTLE): go to FAULT with the lowest such i.
  - Otherwise REQ=0: go to DOWN starting at the current idx (highest enabled group).
- FAULT: all EN cleared on entry. FAULT=1 and FAULT_CH are held until CLR=1 and REQ=0, then go to OFF. A fault-to-OFF exit never re-powers while REQ=1.
- Priority within one cycle: fault > REQ deassert > normal advance.
- BUSY = state in {UP, SETTLE, DOWN}.

## Timing
- Reset values: EN=0, READY=0, BUSY=0, FAULT=0, FAULT_CH=0, state=OFF, idx=0, tmr=0, debounce counters and synchronisers=0.
- All outputs are registered and change on the clock edge where the state transition is taken.
- REQ sampled 1 in cycle t -> EN[0]=1 at t+1.
- PG rise to pg_ok: 2 synchroniser cycles + DEB_CNT cycles. pg_ok to next EN bit: STEP_DLY+1 cycles.
- Timeout: FAULT asserts TIMEOUT+1 cycles after EN[idx] rises.
- PG drop in ON: FAULT=1 and EN=0 three cycles after the pad PG falls (2 synchroniser cycles + 1 register).
- DOWN: successive EN bits fall STEP_DLY+1 cycles apart. BUSY clears with the final step.
- RST mid-sequence: all outputs return to reset values on the next edge. EN drops at once, with no reverse order.

## Test plan
Parameters for all scenarios: NCH=4, DEB_CNT=4, STEP_DLY=8, TIMEOUT=20.
- Normal up: REQ=1, each PG tied high 3 cycles after its EN -> EN goes 0001, 0011, 0111, 1111 in order; READY=1; BUSY=0; FAULT=0.
- Normal down: from READY, REQ=0 -> EN goes 0111, 0011, 0001, 0000 at 9-cycle spacing; then OFF with BUSY=0.
- Timeout: PG[2] held low -> FAULT=1, FAULT_CH=2, EN=0000, 21 cycles after EN[2] rose. REQ=0 with CLR=1 -> FAULT=0; a new REQ sequences again.
- Dropout: in ON, pulse PG[1] and PG[3] low together -> FAULT_CH=1 and EN=0000, 3 cycles after the drop.
- Debounce: PG[0] glitch pattern high 3 / low 1 / high 4 -> EN[1] rises only after the 4-cycle high run plus 9 cycles; no fault.
- Abort and reset: REQ drops while in SETTLE at idx=1 -> DOWN from idx=1, giving EN 0001 then 0000. RST asserted in UP -> all outputs at reset values next cycle.
